// File: rtl/cmd_input_conditioner.sv
// Panel input conditioner: synchronizes and debounces the selector, start and stop
// inputs, then latches a validated command code behind a valid/ready handshake.
module cmd_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw_raw,
    input  logic       start_raw,
    input  logic       stop_raw,
    input  logic       cmd_ready,
    input  logic       cmd_done,
    output logic [2:0] I,
    output logic       cmd_valid,
    output logic       S,
    output logic       err
);

    localparam int NBITS     = 5;
    localparam int BIT_START = 3;
    localparam int BIT_STOP  = 4;
    localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_RUN
    } state_t;

    logic [NBITS-1:0]            raw_bus;
    logic [NBITS-1:0]            sync_q1;
    logic [NBITS-1:0]            sync_q2;
    logic [NBITS-1:0]            deb_q;
    logic [NBITS-1:0][CNT_W-1:0] cnt_q;

    logic [2:0] deb_sw;
    logic       deb_start;
    logic       deb_stop;
    logic       deb_start_q;
    logic [1:0] prime_q;
    logic       armed_q;
    logic       start_rise;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] i_d;
    logic       valid_d;
    logic       err_d;

    assign raw_bus   = {stop_raw, start_raw, sw_raw};
    assign deb_sw    = deb_q[2:0];
    assign deb_start = deb_q[BIT_START];
    assign deb_stop  = deb_q[BIT_STOP];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_bus;
            sync_q2 <= sync_q1;
        end
    end

    // NOTE: the counter array is state, not storage, so it is cleared by reset like any flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int b = 0; b < NBITS; b++) begin
                if (sync_q2[b] == deb_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CNT_LAST) begin
                    deb_q[b] <= sync_q2[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    // Start arms only after the synced button is seen released, so a press held
    // through reset cannot replay a command once reset lifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prime_q     <= '0;
            armed_q     <= 1'b0;
            deb_start_q <= 1'b0;
            S           <= 1'b0;
        end else begin
            prime_q     <= {prime_q[0], 1'b1};
            if (prime_q[1] && !sync_q2[BIT_START] && !deb_start) begin
                armed_q <= 1'b1;
            end
            deb_start_q <= deb_start;
            S           <= deb_stop;
        end
    end

    assign start_rise = armed_q & deb_start & ~deb_start_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            I         <= 3'b000;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            I         <= i_d;
            cmd_valid <= valid_d;
            err       <= err_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        i_d     = I;
        valid_d = cmd_valid;
        err_d   = 1'b0;
        if (deb_stop) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        if (deb_sw != 3'b000) begin
                            i_d     = deb_sw;
                            valid_d = 1'b1;
                            state_d = ST_PEND;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    if (cmd_valid && cmd_ready) begin
                        valid_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cmd_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_input_conditioner.sv
// Self-checking bench for cmd_input_conditioner: directed scenarios plus randomized
// button/switch activity compared against a behavioural model of the panel front end.
module tb_cmd_input_conditioner;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sw_raw;
    logic       start_raw;
    logic       stop_raw;
    logic       cmd_ready;
    logic       cmd_done;
    logic [2:0] I;
    logic       cmd_valid;
    logic       S;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    cmd_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .start_raw (start_raw),
        .stop_raw  (stop_raw),
        .cmd_ready (cmd_ready),
        .cmd_done  (cmd_done),
        .I         (I),
        .cmd_valid (cmd_valid),
        .S         (S),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: raw bits reach the debouncer two samples late; a debounced bit
    // flips once the last DEB samples all disagree with it.
    typedef enum logic [1:0] {M_IDLE, M_PEND, M_RUN} m_state_t;

    logic [4:0] m_pipe[$];
    logic [4:0] m_hist[$];
    logic [4:0] m_deb;
    logic       m_deb_start_q;
    logic       m_armed;
    int         m_edges;
    m_state_t   m_state;
    logic [2:0] m_I;
    logic       m_valid;
    logic       m_S;
    logic       m_err;

    logic [5:0] dut_o;
    logic [5:0] mod_o;
    assign dut_o = {I, cmd_valid, S, err};
    assign mod_o = {m_I, m_valid, m_S, m_err};

    task automatic model_reset();
        m_pipe.delete();
        m_pipe.push_back(5'd0);
        m_pipe.push_back(5'd0);
        m_hist.delete();
        m_deb         = 5'd0;
        m_deb_start_q = 1'b0;
        m_armed       = 1'b0;
        m_edges       = 0;
        m_state       = M_IDLE;
        m_I           = 3'b000;
        m_valid       = 1'b0;
        m_S           = 1'b0;
        m_err         = 1'b0;
    endtask

    task automatic model_edge();
        logic [4:0] raw;
        logic [4:0] synced;
        logic [4:0] deb_new;
        logic       rise;
        logic       all_diff;
        raw    = {stop_raw, start_raw, sw_raw};
        synced = m_pipe.pop_front();
        m_pipe.push_back(raw);
        m_hist.push_back(synced);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        deb_new = m_deb;
        if (m_hist.size() == DEB) begin
            for (int b = 0; b < 5; b++) begin
                all_diff = 1'b1;
                foreach (m_hist[k]) if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) deb_new[b] = ~m_deb[b];
            end
        end
        rise  = m_armed && m_deb[3] && !m_deb_start_q;
        m_err = 1'b0;
        if (m_deb[4]) begin
            m_state = M_IDLE;
            m_valid = 1'b0;
        end else begin
            case (m_state)
                M_IDLE: if (rise) begin
                    if (m_deb[2:0] != 3'b000) begin
                        m_I     = m_deb[2:0];
                        m_valid = 1'b1;
                        m_state = M_PEND;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                M_PEND: if (cmd_ready) begin
                    m_valid = 1'b0;
                    m_state = M_RUN;
                end
                M_RUN: if (cmd_done) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end
        if (m_edges >= 2 && !synced[3] && !m_deb[3]) m_armed = 1'b1;
        m_S           = m_deb[4];
        m_deb_start_q = m_deb[3];
        m_deb         = deb_new;
        m_edges++;
    endtask

    // One clock: drive at the falling edge, step the model on the rising edge, return at the next falling edge.
    task automatic step(input logic [2:0] sw, input logic st, input logic sp,
                        input logic rdy, input logic dn);
        sw_raw    = sw;
        start_raw = st;
        stop_raw  = sp;
        cmd_ready = rdy;
        cmd_done  = dn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        sw_raw    = 3'b111;
        start_raw = 1'b1;
        stop_raw  = 1'b1;
        cmd_ready = 1'b1;
        cmd_done  = 1'b1;
        reset     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_o !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b", dut_o, 6'b000000);
        end
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (dut_o !== 6'b000000) begin
                n_err++;
                $display("FAIL reset_idle step %0d: got %b expected %b", i, dut_o, 6'b000000);
            end
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 14; i++) begin
            step(3'b101, i <= 10, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (cmd_valid !== (i == 7)) begin
                n_err++;
                $display("FAIL basic_valid step %0d: got %b expected %b", i, cmd_valid, (i == 7));
            end
            n_cmp++;
            if (dut_o !== mod_o) begin
                n_err++;
                $display("FAIL basic_model step %0d: got %b expected %b", i, dut_o, mod_o);
            end
        end
        n_cmp++;
        if (I !== 3'b101) begin
            n_err++;
            $display("FAIL basic_code: got %b expected %b", I, 3'b101);
        end
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        settle(8);
    endtask

    task automatic test_glitch();
        for (int i = 1; i <= 14; i++) begin
            step(3'b101, i <= 3, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({cmd_valid, err} !== 2'b00) begin
                n_err++;
                $display("FAIL glitch_quiet step %0d: got %b expected %b", i, {cmd_valid, err}, 2'b00);
            end
            n_cmp++;
            if (dut_o !== mod_o) begin
                n_err++;
                $display("FAIL glitch_model step %0d: got %b expected %b", i, dut_o, mod_o);
            end
        end
        settle(4);
    endtask

    task automatic test_zero_code();
        for (int i = 1; i <= 14; i++) begin
            step(3'b000, i <= 10, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({I, cmd_valid, err} !== {3'b101, 1'b0, (i == 7)}) begin
                n_err++;
                $display("FAIL zero_code step %0d: got %b expected %b", i,
                         {I, cmd_valid, err}, {3'b101, 1'b0, (i == 7)});
            end
        end
        settle(8);
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 16; i++) begin
            step(3'b011, i <= 10, 1'b0, i >= 13, 1'b0);
            n_cmp++;
            if (cmd_valid !== (i >= 7 && i <= 12)) begin
                n_err++;
                $display("FAIL bp_valid step %0d: got %b expected %b", i, cmd_valid, (i >= 7 && i <= 12));
            end
            n_cmp++;
            if (dut_o !== mod_o) begin
                n_err++;
                $display("FAIL bp_model step %0d: got %b expected %b", i, dut_o, mod_o);
            end
        end
        settle(8);
        // A second press while running must be ignored, even with new switches.
        for (int i = 1; i <= 14; i++) begin
            step(3'b110, i <= 10, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({I, cmd_valid, err} !== {3'b011, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_run_ignore step %0d: got %b expected %b", i,
                         {I, cmd_valid, err}, {3'b011, 1'b0, 1'b0});
            end
        end
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        settle(8);
    endtask

    task automatic test_stop();
        for (int i = 1; i <= 8; i++) step(3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
        settle(8);
        for (int i = 1; i <= 20; i++) begin
            step(3'b110, i >= 3 && i <= 14, i <= 10, 1'b1, i == 7);
            n_cmp++;
            if ({S, cmd_valid, err} !== {(i >= 7 && i <= 16), 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL stop_level step %0d: got %b expected %b", i,
                         {S, cmd_valid, err}, {(i >= 7 && i <= 16), 1'b0, 1'b0});
            end
            n_cmp++;
            if (dut_o !== mod_o) begin
                n_err++;
                $display("FAIL stop_model step %0d: got %b expected %b", i, dut_o, mod_o);
            end
        end
        settle(10);
        // After stop the controller is idle and accepts a fresh press.
        for (int i = 1; i <= 10; i++) begin
            step(3'b100, 1'b1, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({I, cmd_valid} !== {(i >= 7) ? 3'b100 : 3'b110, (i == 7)}) begin
                n_err++;
                $display("FAIL stop_restart step %0d: got %b expected %b", i,
                         {I, cmd_valid}, {(i >= 7) ? 3'b100 : 3'b110, (i == 7)});
            end
        end
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        settle(8);
    endtask

    task automatic test_reset_midop();
        for (int i = 1; i <= 9; i++) begin
            step(3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (cmd_valid !== (i >= 7)) begin
                n_err++;
                $display("FAIL midop_pend step %0d: got %b expected %b", i, cmd_valid, (i >= 7));
            end
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_o !== 6'b000000) begin
            n_err++;
            $display("FAIL midop_reset_immediate: got %b expected %b", dut_o, 6'b000000);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({cmd_valid, err} !== 2'b00) begin
                n_err++;
                $display("FAIL midop_no_replay step %0d: got %b expected %b", i, {cmd_valid, err}, 2'b00);
            end
        end
        settle(8);
        for (int i = 1; i <= 10; i++) begin
            step(3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (cmd_valid !== (i == 7)) begin
                n_err++;
                $display("FAIL midop_repress step %0d: got %b expected %b", i, cmd_valid, (i == 7));
            end
        end
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        settle(8);
    endtask

    task automatic test_random(input int n);
        logic       st_lvl;
        logic       sp_lvl;
        logic [2:0] sw_lvl;
        logic [2:0] sw;
        logic       st;
        logic       sp;
        st_lvl = 1'b0;
        sp_lvl = 1'b0;
        sw_lvl = 3'b001;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 24) == 0) st_lvl = ~st_lvl;
            if ($urandom_range(0, sp_lvl ? 30 : 250) == 0) sp_lvl = ~sp_lvl;
            if ($urandom_range(0, 39) == 0) sw_lvl = 3'($urandom_range(0, 7));
            sw = sw_lvl;
            if ($urandom_range(0, 19) == 0) sw = sw ^ 3'($urandom_range(1, 7));
            st = st_lvl ^ ($urandom_range(0, 19) == 0);
            sp = sp_lvl ^ ($urandom_range(0, 49) == 0);
            step(sw, st, sp, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
            n_cmp++;
            if (dut_o !== mod_o) begin
                n_err++;
                $display("FAIL random step %0d: got %b expected %b", i, dut_o, mod_o);
            end
            if ($urandom_range(0, 699) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                n_cmp++;
                if (dut_o !== 6'b000000) begin
                    n_err++;
                    $display("FAIL random_reset step %0d: got %b expected %b", i, dut_o, 6'b000000);
                end
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_zero_code();
        test_backpressure();
        test_stop();
        test_reset_midop();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
